// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the T flip-flop counter controller.
//   state_t            : controller states IDLE / RUN / DONE
//   TFF_WIDTH_DEFAULT  : default counter width in bits
package tff_ctrl_pkg;

    localparam int TFF_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop with synchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears q
//   t     : toggle enable
//   q     : flip-flop state
module tff_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// Start/stop controlled up-counter built from WIDTH T flip-flops. The
// controller only steers the T inputs: increment, clear (T=Q) or hold.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : begin counting (accepted in IDLE when stop=0)
//   stop  : abort; clears count and returns to IDLE
//   mode  : 0 one-shot, 1 auto-reload (latched with start)
//   term  : terminal count (latched with start)
//   count : T flip-flop Q vector
//   busy  : registered, high in RUN or DONE
//   done  : registered, one-cycle pulse on terminal count
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = TFF_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] term_q, term_nxt;
    logic             mode_q, mode_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] t_inc;
    logic [WIDTH-1:0] t;

    // Ripple-carry toggle pattern: bit i toggles when all lower bits are 1.
    always_comb begin
        t_inc[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++)
            t_inc[i] = t_inc[i-1] & count[i-1];
    end

    always_comb begin
        state_nxt = state;
        term_nxt  = term_q;
        mode_nxt  = mode_q;
        done_nxt  = 1'b0;
        t         = '0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    term_nxt  = term;
                    mode_nxt  = mode;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // stop outranks a terminal match in the same cycle
                if (stop) begin
                    t         = count;
                    state_nxt = IDLE;
                end else if (count == term_q) begin
                    done_nxt = 1'b1;
                    if (mode_q) begin
                        t = count;          // reload to 0, stay in RUN
                    end else begin
                        state_nxt = DONE;   // hold at term for the DONE cycle
                    end
                end else begin
                    t = t_inc;
                end
            end
            DONE: begin
                t         = count;
                state_nxt = IDLE;
            end
            default: begin
                t         = count;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            term_q <= '0;
            mode_q <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            term_q <= term_nxt;
            mode_q <= mode_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != IDLE);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_bit u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t[i]),
            .q     (count[i])
        );
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed bench for tff_count_ctrl: each step pushes the expected
// {count, busy, done} after the next edge onto a queue, then pops and
// checks it once the edge has passed.
module tb_tff_count_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] term;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    typedef struct {
        string        tag;
        logic [W-1:0] count;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .term  (term),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one edge and check outputs 1 time unit later.
    task automatic step(input string tag, input logic [W-1:0] c,
                        input logic b, input logic d);
        exp_t e, got;
        e.tag = tag; e.count = c; e.busy = b; e.done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        total++;
        assert ({count, busy, done} === {got.count, got.busy, got.done})
        else begin
            bad++;
            $error("FAIL %s: count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                   got.tag, count, busy, done, got.count, got.busy, got.done);
        end
    endtask

    task automatic go(input logic m, input logic [W-1:0] tv);
        start = 1'b1; mode = m; term = tv;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; term = '0;

        // reset state
        step("reset0", 0, 0, 0);
        step("reset1", 0, 0, 0);
        rst_n = 1'b1;
        step("idle", 0, 0, 0);

        // one-shot term=3; term/mode changes after acceptance ignored
        go(1'b0, 8'd3);
        step("os_acc", 0, 1, 0);
        start = 1'b0; term = 8'd99; mode = 1'b1;
        step("os_c1", 1, 1, 0);
        step("os_c2", 2, 1, 0);
        step("os_c3", 3, 1, 0);
        step("os_done", 3, 1, 1);
        step("os_idle", 0, 0, 0);

        // auto-reload term=2, period 3
        go(1'b1, 8'd2);
        step("ar_acc", 0, 1, 0);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step("ar_c1", 1, 1, 0);
            step("ar_c2", 2, 1, 0);
            step("ar_wrap", 0, 1, 1);
        end
        step("ar_c1b", 1, 1, 0);
        stop = 1'b1;
        step("ar_stop", 0, 0, 0);
        stop = 1'b0;

        // abort at count 4
        go(1'b0, 8'd10);
        step("ab_acc", 0, 1, 0);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step("ab_run", k[W-1:0], 1, 0);
        stop = 1'b1;
        step("ab_stop", 0, 0, 0);
        stop = 1'b0;
        step("ab_idle", 0, 0, 0);

        // start mid-run ignored
        go(1'b0, 8'd3);
        step("ig_acc", 0, 1, 0);
        go(1'b1, 8'd5);
        step("ig_c1", 1, 1, 0);
        step("ig_c2", 2, 1, 0);
        start = 1'b0;
        step("ig_c3", 3, 1, 0);
        step("ig_done", 3, 1, 1);
        step("ig_idle", 0, 0, 0);

        // start+stop together in IDLE
        go(1'b0, 8'd3); stop = 1'b1;
        step("ss_idle", 0, 0, 0);
        start = 1'b0; stop = 1'b0;
        step("ss_idle2", 0, 0, 0);

        // stop beats terminal match
        go(1'b0, 8'd2);
        step("sp_acc", 0, 1, 0);
        start = 1'b0;
        step("sp_c1", 1, 1, 0);
        step("sp_c2", 2, 1, 0);
        stop = 1'b1;
        step("sp_stop", 0, 0, 0);
        stop = 1'b0;

        // reset mid-run at count 5, then start on first edge after release
        go(1'b0, 8'd20);
        step("rr_acc", 0, 1, 0);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) step("rr_run", k[W-1:0], 1, 0);
        rst_n = 1'b0;
        step("rr_low0", 0, 0, 0);
        step("rr_low1", 0, 0, 0);
        rst_n = 1'b1; go(1'b0, 8'd1);
        step("rr_acc2", 0, 1, 0);
        start = 1'b0;
        step("rr_c1", 1, 1, 0);
        step("rr_done", 1, 1, 1);
        step("rr_idle", 0, 0, 0);

        // term=0 one-shot
        go(1'b0, 8'd0);
        step("t0_acc", 0, 1, 0);
        start = 1'b0;
        step("t0_done", 0, 1, 1);
        step("t0_idle", 0, 0, 0);

        // term=0 auto-reload: done every cycle
        go(1'b1, 8'd0);
        step("t0r_acc", 0, 1, 0);
        start = 1'b0;
        step("t0r_d1", 0, 1, 1);
        step("t0r_d2", 0, 1, 1);
        stop = 1'b1;
        step("t0r_stop", 0, 0, 0);
        stop = 1'b0;

        // full range term=255
        go(1'b0, 8'd255);
        step("tf_acc", 0, 1, 0);
        start = 1'b0;
        for (int k = 1; k <= 255; k++) step("tf_run", k[W-1:0], 1, 0);
        step("tf_done", 255, 1, 1);
        step("tf_idle", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
